// File: rtl/uart_rx.sv
// UART receiver: 2-flop line sync, 16x-oversampled start/data/stop sampling, one byte per frame.
// Optional even parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 b_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd4;
`endif

   logic                 rx_meta;
   logic                 rx_s;
   logic [2:0]           state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 stop_ok;
   logic                 at_end;

   // Both flops reset to the idle level so reset release never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign at_end = b_tick && (tick_cnt == TICK_END);

`ifdef UART_RX_PARITY_EN
   logic par_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_err <= 1'b0;
      end else if (state == PARITY && at_end) begin
         par_err <= (^shreg) ^ rx_s;
      end
   end

   assign stop_ok = rx_s && !par_err;
`else
   assign stop_ok = rx_s;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
                  rx_busy  <= 1'b1;
               end
            end

            START: begin
               if (b_tick) begin
                  if (tick_cnt == TICK_MID) begin
                     if (!rx_s) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end else begin
                        // Low pulse shorter than half a bit: treat as noise.
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            DATA: begin
               if (at_end) begin
                  shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                  tick_cnt <= '0;
                  if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (b_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_end) begin
                  state    <= STOP;
                  tick_cnt <= '0;
               end else if (b_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
`endif

            STOP: begin
               // Leaving at mid-stop gives the next start edge half a bit of slack.
               if (at_end) begin
                  if (stop_ok) begin
                     rx_data <= shreg;
                     rx_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state    <= IDLE;
                  tick_cnt <= '0;
                  rx_busy  <= 1'b0;
               end else if (b_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end

            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial driver pushes expected outcomes, a monitor checks every pulse.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DB    = 8;
   localparam int OS    = 16;
   localparam int TDIV  = 4;
   localparam int BIT   = OS * TDIV;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   // Start detect to stop sample, in ticks.
   localparam int PERIOD = OS / 2 + OS * (DB + PAR + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          b_tick = 1'b0;
   logic          rx = 1'b1;
   logic [DB-1:0] rx_data;
   logic          rx_done;
   logic          rx_busy;
   logic          frame_err;

   int compared = 0;
   int mismatched = 0;

   logic [DB:0]   expq[$];   // {is_err, data}
   logic [DB-1:0] last_good = '0;
   logic          prev_done = 1'b0;
   logic          prev_err = 1'b0;

   uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx),
      .rx_data(rx_data), .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      int tdiv = 0;
      forever begin
         @(negedge clk);
         tdiv = (tdiv + 1) % TDIV;
         b_tick = (tdiv == 0);
      end
   end

   initial begin
      #(900_000);
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic hold(input logic v, input int clks);
      rx = v;
      repeat (clks) @(negedge clk);
   endtask

   // Drives one frame; a bad stop bit is low for 3/4 bit then followed by extra idle.
   task automatic send_frame(input logic [DB-1:0] d, input bit bad_stop, input bit bad_par);
      logic perr;
      perr = (PAR != 0) && bad_par;
      expq.push_back({bad_stop || perr, d});
      hold(1'b0, BIT);
      for (int i = 0; i < DB; i++) hold(d[i], BIT);
      if (PAR != 0) hold((^d) ^ bad_par, BIT);
      if (bad_stop) begin
         hold(1'b0, (OS * 3 / 4) * TDIV);
         hold(1'b1, (OS / 4) * TDIV + BIT);
      end else begin
         hold(1'b1, BIT);
      end
   endtask

   // Monitor: every rx_done / frame_err pulse is matched against the queue head.
   initial begin
      logic [DB:0]   e;
      logic [DB-1:0] want;
      forever begin
         @(negedge clk);
         if (rx_done || frame_err) begin
            chk("done_and_err_together", int'(rx_done && frame_err), 0);
            chk("pulse_longer_than_1clk",
                int'((rx_done && prev_done) || (frame_err && prev_err)), 0);
            if (expq.size() == 0) begin
               chk("unexpected_pulse", {rx_done, frame_err}, 0);
            end else begin
               e = expq.pop_front();
               chk("outcome_is_err", int'(frame_err), int'(e[DB]));
               want = e[DB] ? last_good : e[DB-1:0];
               chk("rx_data", int'(rx_data), int'(want));
               if (!e[DB]) last_good = e[DB-1:0];
            end
         end
         prev_done = rx_done;
         prev_err  = frame_err;
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_rx_data", int'(rx_data), 0);
      chk("reset_rx_done", int'(rx_done), 0);
      chk("reset_rx_busy", int'(rx_busy), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      rst = 1'b1;
      hold(1'b1, 2 * BIT);

      // Single frame, then busy must already be low half a bit after mid-stop.
      send_frame(8'h55, 0, 0);
      chk("busy_after_0x55", int'(rx_busy), 0);

      // Bad stop bit: frame_err, rx_data keeps 0x55.
      send_frame(8'h81, 1, 0);
      chk("busy_after_bad_stop", int'(rx_busy), 0);

      // Back-to-back frames with no idle gap.
      send_frame(8'hA5, 0, 0);
      send_frame(8'h3C, 0, 0);
      send_frame(8'hFF, 0, 0);
      hold(1'b1, BIT);

      // Short low glitch: busy while judging, then back to idle without pulses.
      hold(1'b0, 20);
      chk("busy_during_glitch", int'(rx_busy), 1);
      hold(1'b1, 2 * BIT);
      chk("busy_after_glitch", int'(rx_busy), 0);

      // Reset in the middle of the data bits of 0x12 aborts it silently.
      hold(1'b0, BIT);
      hold(1'b0, BIT);
      hold(1'b1, BIT);
      hold(1'b0, BIT / 2);
      rst = 1'b0;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("midframe_reset_busy", int'(rx_busy), 0);
      chk("midframe_reset_data", int'(rx_data), 0);
      last_good = '0;
      rst = 1'b1;
      hold(1'b1, BIT);
      send_frame(8'h34, 0, 0);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 0, 0);
      send_frame(8'h07, 0, 1);
`endif

      // Break: line held low yields one frame_err per frame period, then recovers.
      hold(1'b1, BIT);
      for (int k = 0; k < 3; k++) expq.push_back({1'b1, {DB{1'b0}}});
      hold(1'b0, (3 * PERIOD + 3) * TDIV);
      hold(1'b1, 2 * BIT);
      chk("busy_after_break", int'(rx_busy), 0);
      send_frame(8'hC3, 0, 0);

      // Randomised frames with random gaps, bad stops and bad parity.
      for (int n = 0; n < 30; n++) begin
         logic [DB-1:0] d;
         bit bs, bp;
         d  = DB'($urandom);
         bs = ($urandom_range(0, 7) == 0);
         bp = ($urandom_range(0, 7) == 0);
         send_frame(d, bs, bp);
         hold(1'b1, $urandom_range(0, 40));
      end

      for (int i = 0; i < 4 * BIT && expq.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);
      chk("final_busy", int'(rx_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
